// File: rtl/hazard_control_if.sv
// Control bundle between the 5-stage core datapath and hazard_control.
// The master side is the datapath (operand/EX fields in, enables out); the slave side is hazard_control.
interface hazard_control_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_memtoReg;
  logic [4:0]       ex_rd;
  logic             ex_halt;
  logic             branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_nop;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memtoReg, ex_rd, ex_halt, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_nop, halted, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memtoReg, ex_rd, ex_halt, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_nop, halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_control.sv
// Load-use stall, taken-branch flush and halt-drain control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush event counters.
module hazard_control #(
  parameter int LOAD_STALL   = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic          clock,
  input  logic          reset,
  hazard_control_if.slave hc
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t     state_reg;
  logic [3:0] stall_left_reg;
  logic [3:0] drain_left_reg;
  logic       halted_reg;
  logic       hz;
  logic       active;

  assign hz = hc.ex_memtoReg && (hc.ex_rd != 5'd0) &&
              ((hc.id_use_rs1 && (hc.id_rs1 == hc.ex_rd)) ||
               (hc.id_use_rs2 && (hc.id_rs2 == hc.ex_rd)));
  assign active = (state_reg == RUN) || (state_reg == STALL);
  assign hc.halted = halted_reg;

  always_comb begin
    hc.pc_write   = 1'b1;
    hc.ifid_write = 1'b1;
    hc.ifid_flush = 1'b0;
    hc.idex_nop   = 1'b0;
    if (!active) begin
      hc.pc_write   = 1'b0;
      hc.ifid_write = 1'b0;
      hc.idex_nop   = 1'b1;
    end else if (hc.ex_halt) begin
      hc.pc_write   = 1'b0;
      hc.ifid_write = 1'b0;
      hc.idex_nop   = 1'b1;
    end else if (hc.branch_taken) begin
      // A taken branch overrides an in-progress stall: the stalled instruction is squashed anyway.
      hc.ifid_flush = 1'b1;
      hc.idex_nop   = 1'b1;
    end else if ((state_reg == STALL) || hz) begin
      hc.pc_write   = 1'b0;
      hc.ifid_write = 1'b0;
      hc.idex_nop   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      stall_left_reg <= 4'd0;
      drain_left_reg <= 4'd0;
      halted_reg     <= 1'b0;
    end else begin
      case (state_reg)
        RUN, STALL: begin
          if (hc.ex_halt) begin
            drain_left_reg <= 4'(DRAIN_CYCLES);
            state_reg      <= DRAIN;
          end else if (hc.branch_taken) begin
            state_reg <= RUN;
          end else if (state_reg == STALL) begin
            if (stall_left_reg == 4'd1) state_reg <= RUN;
            else stall_left_reg <= stall_left_reg - 4'd1;
          end else if (hz && (LOAD_STALL > 1)) begin
            // The detection cycle is the first stall cycle, so LOAD_STALL-1 remain.
            stall_left_reg <= 4'(LOAD_STALL - 1);
            state_reg      <= STALL;
          end
        end
        DRAIN: begin
          if (drain_left_reg == 4'd1) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end else begin
            drain_left_reg <= drain_left_reg - 4'd1;
          end
        end
        default: state_reg <= HALTED;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic             stall_evt;
  logic             flush_evt;

  assign stall_evt = active && !hc.ex_halt && !hc.branch_taken && ((state_reg == STALL) || hz);
  assign flush_evt = active && !hc.ex_halt && hc.branch_taken;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && !(&stall_cnt_reg)) stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_evt && !(&flush_cnt_reg)) flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign hc.stall_count = stall_cnt_reg;
  assign hc.flush_count = flush_cnt_reg;
`else
  assign hc.stall_count = '0;
  assign hc.flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: two instances (LOAD_STALL=1 with 3-bit counters, LOAD_STALL=3 with 32-bit)
// share one stimulus stream and are checked every cycle against a remaining-cycles model.
module tb_hazard_control;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int DRAIN = 3;
  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_HALT = 3, M_FROZEN = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memtoReg, ex_halt, branch_taken;

  always #5 clock = ~clock;

  hazard_control_if #(.CNT_W(3))  ifa ();
  hazard_control_if #(.CNT_W(32)) ifb ();

  assign ifa.id_rs1 = id_rs1;           assign ifb.id_rs1 = id_rs1;
  assign ifa.id_rs2 = id_rs2;           assign ifb.id_rs2 = id_rs2;
  assign ifa.id_use_rs1 = id_use_rs1;   assign ifb.id_use_rs1 = id_use_rs1;
  assign ifa.id_use_rs2 = id_use_rs2;   assign ifb.id_use_rs2 = id_use_rs2;
  assign ifa.ex_memtoReg = ex_memtoReg; assign ifb.ex_memtoReg = ex_memtoReg;
  assign ifa.ex_rd = ex_rd;             assign ifb.ex_rd = ex_rd;
  assign ifa.ex_halt = ex_halt;         assign ifb.ex_halt = ex_halt;
  assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;

  hazard_control #(.LOAD_STALL(1), .DRAIN_CYCLES(DRAIN), .CNT_W(3)) u_a (
    .clock(clock), .reset(reset), .hc(ifa.slave));
  hazard_control #(.LOAD_STALL(3), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) u_b (
    .clock(clock), .reset(reset), .hc(ifb.slave));

  // Model: remaining stall/drain cycles and event totals for each instance
  int     stall_left [2];
  int     drain_left [2];
  bit     mhalt      [2];
  longint stalls     [2];
  longint flushes    [2];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic int ls_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic longint sat_inc(longint v, int k);
    longint mx;
    mx = (k == 0) ? 64'd7 : 64'hFFFF_FFFF;
    return (v < mx) ? v + 1 : v;
  endfunction

  function automatic bit hz_f();
    return ex_memtoReg && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic int decide(int k);
    if (mhalt[k] || drain_left[k] > 0) return M_FROZEN;
    if (ex_halt) return M_HALT;
    if (branch_taken) return M_FLUSH;
    if (stall_left[k] > 0 || hz_f()) return M_STALL;
    return M_RUN;
  endfunction

  task automatic chk(input int k, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s_%s t=%0t: got %0d expected %0d", (k == 0) ? "A" : "B", nm, $time, act, exp);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        stall_left[k] = 0; drain_left[k] = 0; mhalt[k] = 1'b0; stalls[k] = 0; flushes[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        case (decide(k))
          M_FROZEN: if (drain_left[k] > 0) begin
            drain_left[k]--;
            if (drain_left[k] == 0) mhalt[k] = 1'b1;
          end
          M_HALT:  drain_left[k] = DRAIN;
          M_FLUSH: begin flushes[k] = sat_inc(flushes[k], k); stall_left[k] = 0; end
          M_STALL: begin
            stalls[k] = sat_inc(stalls[k], k);
            stall_left[k] = (stall_left[k] > 0) ? stall_left[k] - 1 : ls_of(k) - 1;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        int m;
        m = decide(k);
        if (k == 0) begin
          chk(k, "pc_write", longint'(ifa.pc_write), longint'(m == M_RUN || m == M_FLUSH));
          chk(k, "ifid_write", longint'(ifa.ifid_write), longint'(m == M_RUN || m == M_FLUSH));
          chk(k, "ifid_flush", longint'(ifa.ifid_flush), longint'(m == M_FLUSH));
          chk(k, "idex_nop", longint'(ifa.idex_nop), longint'(m != M_RUN));
          chk(k, "halted", longint'(ifa.halted), longint'(mhalt[k]));
          chk(k, "stall_count", longint'(ifa.stall_count), PERF ? stalls[k] : 0);
          chk(k, "flush_count", longint'(ifa.flush_count), PERF ? flushes[k] : 0);
        end else begin
          chk(k, "pc_write", longint'(ifb.pc_write), longint'(m == M_RUN || m == M_FLUSH));
          chk(k, "ifid_write", longint'(ifb.ifid_write), longint'(m == M_RUN || m == M_FLUSH));
          chk(k, "ifid_flush", longint'(ifb.ifid_flush), longint'(m == M_FLUSH));
          chk(k, "idex_nop", longint'(ifb.idex_nop), longint'(m != M_RUN));
          chk(k, "halted", longint'(ifb.halted), longint'(mhalt[k]));
          chk(k, "stall_count", longint'(ifb.stall_count), PERF ? stalls[k] : 0);
          chk(k, "flush_count", longint'(ifb.flush_count), PERF ? flushes[k] : 0);
        end
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_memtoReg = 1'b0; ex_rd = 5'd0; ex_halt = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2);
    idle();
    ex_memtoReg = 1'b1; ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic counts(input string tag, input longint sa, input longint fa, input longint sb, input longint fb);
    chk(0, {tag, "_stalls"}, longint'(ifa.stall_count), PERF ? sa : 0);
    chk(0, {tag, "_flushes"}, longint'(ifa.flush_count), PERF ? fa : 0);
    chk(1, {tag, "_stalls"}, longint'(ifb.stall_count), PERF ? sb : 0);
    chk(1, {tag, "_flushes"}, longint'(ifb.flush_count), PERF ? fb : 0);
    $display("[%0t] %s: A stall=%0d flush=%0d  B stall=%0d flush=%0d", $time, tag,
             ifa.stall_count, ifa.flush_count, ifb.stall_count, ifb.flush_count);
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    tick(); tick();
    chk(1, "rst_pc_write", longint'(ifb.pc_write), 1);
    chk(1, "rst_ifid_write", longint'(ifb.ifid_write), 1);
    chk(1, "rst_idex_nop", longint'(ifb.idex_nop), 0);
    chk(1, "rst_ifid_flush", longint'(ifb.ifid_flush), 0);
    chk(1, "rst_halted", longint'(ifb.halted), 0);
    counts("reset", 0, 0, 0, 0);

    load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    #1;
    chk(0, "hz_pc_write", longint'(ifa.pc_write), 0);
    chk(0, "hz_idex_nop", longint'(ifa.idex_nop), 1);
    chk(1, "hz_pc_write", longint'(ifb.pc_write), 0);
    tick(); idle(); #1;
    chk(0, "hz_done_pc_write", longint'(ifa.pc_write), 1);
    repeat (4) tick();
    counts("rs1_hazard", 1, 0, 3, 0);

    load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1; chk(1, "rd0_pc_write", longint'(ifb.pc_write), 1);
    tick();
    load_use(5'd6, 5'd6, 5'd1, 1'b0, 1'b1);
    #1; chk(1, "nouse_pc_write", longint'(ifb.pc_write), 1);
    tick(); idle(); repeat (2) tick();
    counts("no_hazard", 1, 0, 3, 0);

    load_use(5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
    tick(); idle(); repeat (4) tick();
    counts("rs2_hazard", 2, 0, 6, 0);

    load_use(5'd9, 5'd0, 5'd9, 1'b0, 1'b1);
    tick(); idle(); tick();
    branch_taken = 1'b1; #1;
    chk(1, "brstall_ifid_flush", longint'(ifb.ifid_flush), 1);
    chk(1, "brstall_pc_write", longint'(ifb.pc_write), 1);
    chk(1, "brstall_idex_nop", longint'(ifb.idex_nop), 1);
    tick(); idle(); #1;
    chk(1, "after_br_pc_write", longint'(ifb.pc_write), 1);
    chk(1, "after_br_idex_nop", longint'(ifb.idex_nop), 0);
    tick();
    counts("branch_abort", 3, 1, 8, 1);

    ex_halt = 1'b1; branch_taken = 1'b1; #1;
    chk(1, "halt_ifid_flush", longint'(ifb.ifid_flush), 0);
    chk(1, "halt_pc_write", longint'(ifb.pc_write), 0);
    tick(); idle(); tick(); tick();
    chk(1, "halted_edge3", longint'(ifb.halted), 0);
    tick();
    chk(0, "halted_edge4", longint'(ifa.halted), 1);
    chk(1, "halted_edge4", longint'(ifb.halted), 1);
    load_use(5'd3, 5'd3, 5'd3, 1'b1, 1'b1); branch_taken = 1'b1;
    tick(); tick(); idle();
    counts("halted", 3, 1, 8, 1);

    #2 reset = 1'b1;
    #1;
    chk(0, "midrst_halted", longint'(ifa.halted), 0);
    chk(1, "midrst_halted", longint'(ifb.halted), 0);
    chk(1, "midrst_pc_write", longint'(ifb.pc_write), 1);
    #2 reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      load_use(5'(i + 1), 5'(i + 1), 5'd0, 1'b1, 1'b0);
      tick(); idle(); repeat (3) tick();
    end
    counts("nine_hazards", 7, 0, 27, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
